sd_wb_slave: RTL and testbench
==============================

Name: sd_wb_slave

Overview:
- Wishbone slave front-end of the SD host controller; consumes the strobe/we/adr/data stream produced by the host-side Wishbone master.
- Returns ack_o, wb_data_o and error_o to that master.
- Decodes a 5-bit address map: 16 general registers, command-execute, TX FIFO write, RX FIFO read, data-execute.
- Issues start pulses to the command and data engines and tracks their busy state until cmd_done_i / data_done_i.

Parameters:
- FIFO_DEPTH, 8, entries in each of the TX and RX 128-bit FIFOs; power of 2, range 2..128.
- CNT_W, 4, FIFO count width; must equal log2(FIFO_DEPTH)+1.

Ports:
- wb_clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- strobe_i  in  1  access request
- we_i  in  1  1 = write, 0 = read
- adr_i  in  5  register/function address
- wb_data_i  in  128  write data
- ack_o  out  1  one-cycle access-complete pulse
- error_o  out  1  one-cycle access-rejected pulse
- wb_data_o  out  128  read data, valid while ack_o=1
- cmd_start_o  out  1  one-cycle pulse to command engine
- data_start_o  out  1  one-cycle pulse to data engine
- cmd_done_i  in  1  command engine finished
- data_done_i  in  1  data engine finished
- tx_data_o  out  128  TX FIFO head (show-ahead)
- tx_rd_i  in  1  pop TX FIFO (data engine)
- tx_empty_o  out  1  TX FIFO empty
- host_data_i  in  128  card-side data into RX FIFO
- host_data_we_i  in  1  push host_data_i into RX FIFO
- rx_full_o  out  1  RX FIFO full

Behaviour:
- Reset (reset=0, async):
  - All outputs 0, except tx_empty_o=1.
  - Registers 0-15 cleared; both FIFOs emptied (pointers and counts 0).
  - cmd_busy, data_busy and rx_ovf cleared.
  - Any in-flight access or pulse is discarded.
- Access acceptance:
  - An access is accepted on a rising edge where strobe_i=1 and both ack_o=0 and error_o=0.
  - Exactly one of ack_o/error_o pulses on the next cycle (latency 1).
  - A continuously held strobe_i therefore produces one response every 2 cycles.
  - adr_i, we_i and wb_data_i are sampled on the acceptance edge only.
- Address map (W = write, R = read):
  - 0-15:
    - W stores wb_data_i.
    - R returns the stored value.
  - 16:
    - W with cmd_busy=0: store wb_data_i as cmd argument (register 0 alias), pulse cmd_start_o in the ack cycle, set cmd_busy.
    - W with cmd_busy=1: error.
    - R returns the status word.
  - 17:
    - W with TX not full: push wb_data_i.
    - W with TX full: error, FIFO unchanged.
    - R returns the status word.
  - 18:
    - R with RX not empty: wb_data_o = RX head, pop.
    - R with RX empty: error.
    - W: error.
  - 19:
    - W with data_busy=0: pulse data_start_o, set data_busy.
    - W with data_busy=1: error.
    - R returns the status word.
  - 20-31: error, no side effect.
- Status word, zero-extended to 128 bits:
  - [0] cmd_busy, [1] data_busy, [2] tx_empty, [3] tx_full, [4] rx_empty, [5] rx_full, [6] rx_ovf.
  - [15:8] TX count, [23:16] RX count.
  - Reading the status at address 16 clears rx_ovf after returning it.
- Busy tracking:
  - cmd_done_i=1 clears cmd_busy on that edge; data_done_i likewise clears data_busy.
  - Done takes effect before the busy check on the same edge, so a write to 16 accepted together with cmd_done_i=1 is acked and starts a new command.
- FIFOs:
  - Circular, FIFO_DEPTH entries; pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH.
  - Simultaneous push and pop is allowed, including on a full FIFO; count is unchanged.
  - tx_rd_i with TX empty is ignored.
  - host_data_we_i with RX full drops the data and sets sticky rx_ovf.
  - A pop on the same edge as a push into a full RX FIFO makes room, so the push succeeds.
- wb_data_o is 0 whenever ack_o=0.

Test Plan:
- Reset, then release -> ack_o=0, error_o=0, tx_empty_o=1, rx_full_o=0; read of address 16 acks with status 0x14.
- Write address 5 = 0xDEAD_BEEF, then read address 5 -> each access gives ack_o exactly 1 cycle after the strobe edge; readback 0xDEAD_BEEF; with strobe_i held high, acks occur every 2 cycles.
- Write address 16 = 0x7 -> cmd_start_o pulse in the ack cycle; second write to 16 -> error_o; cmd_done_i pulse, then write to 16 -> ack_o plus cmd_start_o.
- Write address 17 nine times with data 1..9 (depth 8) -> 8 acks then 1 error; tx_rd_i pops -> tx_data_o sequence 1..8; tx_empty_o=1 after the 8th pop.
- Push host_data_i values 10,15,20 -> three reads of address 18 return 10,15,20; fourth read -> error_o.
- Read address 25 -> error_o, no state change. Assert reset while cmd_busy=1 and TX holds 3 entries -> status returns 0x14 after release, with no cmd_start_o pulse.

Source files
------------

// File: rtl/sd_wb_slave.sv
// -----------------------------------------------------------------------------
// sd_wb_slave
// Wishbone slave front-end of the SD host controller.
//
// It decodes a 5-bit address map:
//   0-15 : general registers
//   16   : command execute (write) / status (read; the read clears rx_ovf)
//   17   : TX FIFO push (write) / status (read)
//   18   : RX FIFO pop (read only)
//   19   : data execute (write) / status (read)
//   20-31: rejected with error_o
//
// It issues start pulses to the command and data engines and holds their
// busy flags until the matching done input arrives.
//
// Ports:
//   wb_clock, reset                  clock, async active-low reset
//   strobe_i, we_i, adr_i, wb_data_i  access request from the Wishbone master
//   ack_o, error_o, wb_data_o         one-cycle response; data is 0 unless ack_o
//   cmd_start_o, cmd_done_i           command engine handshake
//   data_start_o, data_done_i         data engine handshake
//   tx_data_o, tx_rd_i, tx_empty_o    TX FIFO read side (show-ahead head)
//   host_data_i, host_data_we_i       RX FIFO write side (card data)
//   rx_full_o                         RX FIFO full
// -----------------------------------------------------------------------------
module sd_wb_slave #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic         wb_clock,
  input  logic         reset,
  input  logic         strobe_i,
  input  logic         we_i,
  input  logic [4:0]   adr_i,
  input  logic [127:0] wb_data_i,
  output logic         ack_o,
  output logic         error_o,
  output logic [127:0] wb_data_o,
  output logic         cmd_start_o,
  output logic         data_start_o,
  input  logic         cmd_done_i,
  input  logic         data_done_i,
  output logic [127:0] tx_data_o,
  input  logic         tx_rd_i,
  output logic         tx_empty_o,
  input  logic [127:0] host_data_i,
  input  logic         host_data_we_i,
  output logic         rx_full_o
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [4:0]       ADR_CMD  = 5'd16;
  localparam logic [4:0]       ADR_TX   = 5'd17;
  localparam logic [4:0]       ADR_RX   = 5'd18;
  localparam logic [4:0]       ADR_DATA = 5'd19;

  logic [127:0]     regs   [16];
  logic [127:0]     tx_mem [FIFO_DEPTH];
  logic [127:0]     rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic             cmd_busy, data_busy, rx_ovf;

  logic             accept;
  logic             tx_empty, tx_full, rx_empty, rx_full;
  logic             tx_push, tx_pop, rx_push, rx_pop, rx_drop;
  logic             acc_ok, reg_we, cmd_go, data_go, ovf_clr;
  logic [127:0]     status, rdata;

  // Decode the access and FIFO traffic for the current edge.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    accept   = strobe_i && !ack_o && !error_o;
    tx_empty = (tx_cnt == '0);
    tx_full  = (tx_cnt == FULL_CNT);
    rx_empty = (rx_cnt == '0);
    rx_full  = (rx_cnt == FULL_CNT);
    tx_pop   = tx_rd_i && !tx_empty;

    status        = '0;
    status[0]     = cmd_busy;
    status[1]     = data_busy;
    status[2]     = tx_empty;
    status[3]     = tx_full;
    status[4]     = rx_empty;
    status[5]     = rx_full;
    status[6]     = rx_ovf;
    status[15:8]  = 8'(tx_cnt);
    status[23:16] = 8'(rx_cnt);

    acc_ok  = 1'b0;
    reg_we  = 1'b0;
    cmd_go  = 1'b0;
    data_go = 1'b0;
    ovf_clr = 1'b0;
    tx_push = 1'b0;
    rx_pop  = 1'b0;
    rdata   = '0;

    if (!adr_i[4]) begin
      acc_ok = 1'b1;
      reg_we = we_i;
      if (!we_i) rdata = regs[adr_i[3:0]];
    end else begin
      case (adr_i)
        ADR_CMD: begin
          if (we_i) begin
            // A done arriving on this edge frees the engine before the check.
            acc_ok = !(cmd_busy && !cmd_done_i);
            cmd_go = acc_ok;
          end else begin
            acc_ok  = 1'b1;
            rdata   = status;
            ovf_clr = 1'b1;
          end
        end
        ADR_TX: begin
          if (we_i) begin
            // A same-edge pop makes room in a full FIFO.
            acc_ok  = !tx_full || tx_pop;
            tx_push = accept && acc_ok;
          end else begin
            acc_ok = 1'b1;
            rdata  = status;
          end
        end
        ADR_RX: begin
          if (!we_i && !rx_empty) begin
            acc_ok = 1'b1;
            rdata  = rx_mem[rx_rd_ptr];
            rx_pop = accept;
          end
        end
        ADR_DATA: begin
          if (we_i) begin
            acc_ok  = !(data_busy && !data_done_i);
            data_go = acc_ok;
          end else begin
            acc_ok = 1'b1;
            rdata  = status;
          end
        end
        default: acc_ok = 1'b0;
      endcase
    end

    rx_push = host_data_we_i && (!rx_full || rx_pop);
    rx_drop = host_data_we_i && !rx_push;
  end

  // Control state, responses and register file.
  always_ff @(posedge wb_clock or negedge reset) begin
    if (!reset) begin
      ack_o        <= 1'b0;
      error_o      <= 1'b0;
      wb_data_o    <= '0;
      cmd_start_o  <= 1'b0;
      data_start_o <= 1'b0;
      cmd_busy     <= 1'b0;
      data_busy    <= 1'b0;
      rx_ovf       <= 1'b0;
      tx_wr_ptr    <= '0;
      tx_rd_ptr    <= '0;
      rx_wr_ptr    <= '0;
      rx_rd_ptr    <= '0;
      tx_cnt       <= '0;
      rx_cnt       <= '0;
      // NOTE: the register file is software-visible, so it is cleared on reset;
      // the FIFO storage below is not, because pointers and counts define
      // which entries are valid.
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      ack_o        <= accept && acc_ok;
      error_o      <= accept && !acc_ok;
      wb_data_o    <= (accept && acc_ok) ? rdata : '0;
      cmd_start_o  <= accept && cmd_go;
      data_start_o <= accept && data_go;
      cmd_busy     <= (cmd_busy && !cmd_done_i) || (accept && cmd_go);
      data_busy    <= (data_busy && !data_done_i) || (accept && data_go);

      if (accept && reg_we) regs[adr_i[3:0]] <= wb_data_i;
      if (accept && cmd_go) regs[0] <= wb_data_i;

      // A fresh overflow outranks a same-edge status read clearing the flag.
      if (rx_drop)                rx_ovf <= 1'b1;
      else if (accept && ovf_clr) rx_ovf <= 1'b0;

      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
      tx_cnt <= tx_cnt + CNT_W'(tx_push) - CNT_W'(tx_pop);
      rx_cnt <= rx_cnt + CNT_W'(rx_push) - CNT_W'(rx_pop);
    end
  end

  always_ff @(posedge wb_clock) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= wb_data_i;
    if (rx_push) rx_mem[rx_wr_ptr] <= host_data_i;
  end

  // The show-ahead head is forced to 0 while empty, so that stale storage never leaks out.
  assign tx_data_o  = tx_empty ? '0 : tx_mem[tx_rd_ptr];
  assign tx_empty_o = tx_empty;
  assign rx_full_o  = rx_full;

endmodule

// File: tb/tb_sd_wb_slave.sv
// -----------------------------------------------------------------------------
// tb_sd_wb_slave
// Self-checking bench for sd_wb_slave. A queue-based reference model
// predicts every response. The stimulus is a mix of directed steps and
// randomized accesses with FIFO and engine side traffic.
// -----------------------------------------------------------------------------
module tb_sd_wb_slave;

  localparam int DEPTH = 8;

  logic         wb_clock = 1'b0;
  logic         reset = 1'b0;
  logic         strobe_i = 1'b0;
  logic         we_i = 1'b0;
  logic [4:0]   adr_i = '0;
  logic [127:0] wb_data_i = '0;
  logic         ack_o, error_o, cmd_start_o, data_start_o;
  logic [127:0] wb_data_o, tx_data_o;
  logic         cmd_done_i = 1'b0;
  logic         data_done_i = 1'b0;
  logic         tx_rd_i = 1'b0;
  logic         tx_empty_o, rx_full_o;
  logic [127:0] host_data_i = '0;
  logic         host_data_we_i = 1'b0;

  sd_wb_slave #(.FIFO_DEPTH(DEPTH), .CNT_W(4)) dut (
    .wb_clock      (wb_clock),
    .reset         (reset),
    .strobe_i      (strobe_i),
    .we_i          (we_i),
    .adr_i         (adr_i),
    .wb_data_i     (wb_data_i),
    .ack_o         (ack_o),
    .error_o       (error_o),
    .wb_data_o     (wb_data_o),
    .cmd_start_o   (cmd_start_o),
    .data_start_o  (data_start_o),
    .cmd_done_i    (cmd_done_i),
    .data_done_i   (data_done_i),
    .tx_data_o     (tx_data_o),
    .tx_rd_i       (tx_rd_i),
    .tx_empty_o    (tx_empty_o),
    .host_data_i   (host_data_i),
    .host_data_we_i(host_data_we_i),
    .rx_full_o     (rx_full_o)
  );

  always #5 wb_clock = ~wb_clock;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [127:0] m_regs [16];
  logic [127:0] m_tx [$];
  logic [127:0] m_rx [$];
  bit           m_cmd_busy, m_data_busy, m_ovf, m_pending;

  // DUT response observed in the most recent cycle that accepted an access.
  logic         a_ack, a_err, a_cs, a_ds;
  logic [127:0] a_data;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] m_status();
    logic [127:0] s;
    s        = '0;
    s[0]     = m_cmd_busy;
    s[1]     = m_data_busy;
    s[2]     = (m_tx.size() == 0);
    s[3]     = (m_tx.size() == DEPTH);
    s[4]     = (m_rx.size() == 0);
    s[5]     = (m_rx.size() == DEPTH);
    s[6]     = m_ovf;
    s[15:8]  = 8'(m_tx.size());
    s[23:16] = 8'(m_rx.size());
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_tx.delete();
    m_rx.delete();
    m_cmd_busy  = 0;
    m_data_busy = 0;
    m_ovf       = 0;
    m_pending   = 0;
  endtask

  // One clock cycle: drive at the falling edge, predict, clock, check at +1.
  task automatic cycle(input logic stb, input logic we, input logic [4:0] adr,
                       input logic [127:0] d, input logic trd, input logic hwe,
                       input logic [127:0] hd, input logic cd, input logic dd,
                       input string tag);
    logic         acc, ok, cs, ds, clr, pop, push;
    logic [127:0] st, rd;
    strobe_i = stb; we_i = we; adr_i = adr; wb_data_i = d;
    tx_rd_i = trd; host_data_we_i = hwe; host_data_i = hd;
    cmd_done_i = cd; data_done_i = dd;

    st = m_status();
    acc = stb && !m_pending;
    ok = 0; cs = 0; ds = 0; clr = 0; push = 0; rd = '0;
    if (cd) m_cmd_busy = 0;
    if (dd) m_data_busy = 0;
    pop = trd && (m_tx.size() > 0);
    if (acc) begin
      if (adr < 5'd16) begin
        ok = 1;
        if (we) m_regs[adr[3:0]] = d;
        else    rd = m_regs[adr[3:0]];
      end else if (adr == 5'd16) begin
        if (we) begin
          ok = !m_cmd_busy;
          if (ok) begin cs = 1; m_cmd_busy = 1; m_regs[0] = d; end
        end else begin
          ok = 1; rd = st; clr = 1;
        end
      end else if (adr == 5'd17) begin
        if (we) begin
          ok = (m_tx.size() - (pop ? 1 : 0)) < DEPTH;
          push = ok;
        end else begin
          ok = 1; rd = st;
        end
      end else if (adr == 5'd18) begin
        if (!we && m_rx.size() > 0) begin ok = 1; rd = m_rx.pop_front(); end
      end else if (adr == 5'd19) begin
        if (we) begin
          ok = !m_data_busy;
          if (ok) begin ds = 1; m_data_busy = 1; end
        end else begin
          ok = 1; rd = st;
        end
      end
    end
    if (clr) m_ovf = 0;
    if (pop) void'(m_tx.pop_front());
    if (push) m_tx.push_back(d);
    if (hwe) begin
      if (m_rx.size() < DEPTH) m_rx.push_back(hd);
      else m_ovf = 1;
    end
    m_pending = acc;

    @(posedge wb_clock);
    #1;
    check_bit({tag, ".ack"}, ack_o, acc && ok);
    check_bit({tag, ".err"}, error_o, acc && !ok);
    check({tag, ".rdata"}, wb_data_o, (acc && ok) ? rd : '0);
    check_bit({tag, ".cmd_start"}, cmd_start_o, cs);
    check_bit({tag, ".data_start"}, data_start_o, ds);
    check({tag, ".tx_head"}, tx_data_o, (m_tx.size() > 0) ? m_tx[0] : '0);
    check_bit({tag, ".tx_empty"}, tx_empty_o, m_tx.size() == 0);
    check_bit({tag, ".rx_full"}, rx_full_o, m_rx.size() == DEPTH);
    if (acc) begin
      a_ack = ack_o; a_err = error_o; a_data = wb_data_o;
      a_cs = cmd_start_o; a_ds = data_start_o;
    end
    strobe_i = 0; tx_rd_i = 0; host_data_we_i = 0; cmd_done_i = 0; data_done_i = 0;
    @(negedge wb_clock);
  endtask

  task automatic side(input logic trd, input logic hwe, input logic [127:0] hd,
                      input logic cd, input logic dd, input string tag);
    cycle(0, 0, 5'd0, '0, trd, hwe, hd, cd, dd, tag);
  endtask

  // An access followed by its response cycle, in which strobe is low.
  task automatic access(input logic we, input logic [4:0] adr, input logic [127:0] d,
                        input string tag);
    cycle(1, we, adr, d, 0, 0, '0, 0, 0, tag);
    side(0, 0, '0, 0, 0, {tag, ".gap"});
  endtask

  initial begin
    logic hold_ack [4];
    model_reset();

    // Reset state while reset is held.
    #12;
    check_bit("rst.ack", ack_o, 1'b0);
    check_bit("rst.err", error_o, 1'b0);
    check_bit("rst.tx_empty", tx_empty_o, 1'b1);
    check_bit("rst.rx_full", rx_full_o, 1'b0);
    check("rst.tx_data", tx_data_o, '0);
    @(negedge wb_clock);
    reset = 1'b1;
    side(0, 0, '0, 0, 0, "idle");
    access(0, 5'd16, '0, "st0");
    check("st0.lit", a_data, 128'h14);

    // Register write/read and back-to-back strobe.
    access(1, 5'd5, 128'hDEAD_BEEF, "w5");
    access(0, 5'd5, '0, "r5");
    check("r5.lit", a_data, 128'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 5'd5, '0, 0, 0, '0, 0, 0, "hold");
      hold_ack[i] = ack_o;
    end
    check_bit("hold.pat0", hold_ack[0], 1'b1);
    check_bit("hold.pat1", hold_ack[1], 1'b0);
    check_bit("hold.pat2", hold_ack[2], 1'b1);
    check_bit("hold.pat3", hold_ack[3], 1'b0);

    // Command engine handshake, including done on the acceptance edge.
    access(1, 5'd16, 128'h7, "cmd1");
    check_bit("cmd1.start.lit", a_cs, 1'b1);
    access(1, 5'd16, 128'h8, "cmd_busy");
    check_bit("cmd_busy.err.lit", a_err, 1'b1);
    side(0, 0, '0, 1, 0, "cmd_done");
    access(1, 5'd16, 128'h9, "cmd2");
    check_bit("cmd2.start.lit", a_cs, 1'b1);
    cycle(1, 1, 5'd16, 128'hA, 0, 0, '0, 1, 0, "cmd_same_edge");
    side(0, 0, '0, 0, 0, "cmd_same_edge.gap");
    access(0, 5'd0, '0, "reg0_alias");
    check("reg0_alias.lit", a_data, 128'hA);
    side(0, 0, '0, 1, 0, "cmd_done2");

    // Data engine handshake.
    access(1, 5'd19, '0, "dat1");
    access(1, 5'd19, '0, "dat_busy");
    side(0, 0, '0, 0, 1, "dat_done");
    access(1, 5'd19, '0, "dat2");
    side(0, 0, '0, 0, 1, "dat_done2");

    // TX FIFO fill beyond depth, then drain in order.
    for (int i = 1; i <= 9; i++) begin
      access(1, 5'd17, 128'(i), "txw");
      check_bit("txw.ack.lit", a_ack, i <= 8);
    end
    for (int i = 1; i <= 8; i++) begin
      check("txhead.lit", tx_data_o, 128'(i));
      side(1, 0, '0, 0, 0, "txpop");
    end
    check_bit("tx_empty.lit", tx_empty_o, 1'b1);

    // RX FIFO in order, underflow, overflow and pop-with-push on full.
    side(0, 1, 128'd10, 0, 0, "rxp");
    side(0, 1, 128'd15, 0, 0, "rxp");
    side(0, 1, 128'd20, 0, 0, "rxp");
    access(0, 5'd18, '0, "rx1"); check("rx1.lit", a_data, 128'd10);
    access(0, 5'd18, '0, "rx2"); check("rx2.lit", a_data, 128'd15);
    access(0, 5'd18, '0, "rx3"); check("rx3.lit", a_data, 128'd20);
    access(0, 5'd18, '0, "rx4"); check_bit("rx4.err.lit", a_err, 1'b1);
    access(1, 5'd18, '0, "rxw");
    for (int i = 0; i < 9; i++) side(0, 1, 128'(100 + i), 0, 0, "rxfill");
    access(0, 5'd16, '0, "ovf_st");
    check_bit("ovf_st.bit6.lit", a_data[6], 1'b1);
    access(0, 5'd16, '0, "ovf_clr");
    check_bit("ovf_clr.bit6.lit", a_data[6], 1'b0);
    cycle(1, 0, 5'd18, '0, 0, 1, 128'd555, 0, 0, "rx_full_swap");
    side(0, 0, '0, 0, 0, "rx_full_swap.gap");
    for (int i = 0; i < 8; i++) access(0, 5'd18, '0, "rxdrain");

    // Unmapped addresses.
    access(0, 5'd25, '0, "adr25");
    check_bit("adr25.err.lit", a_err, 1'b1);
    access(1, 5'd30, 128'h1234, "adr30");
    access(0, 5'd16, '0, "post_unmapped");

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      logic [4:0] adr;
      int         r;
      r = $urandom_range(0, 9);
      if (r < 3)       adr = 5'($urandom_range(0, 15));
      else if (r == 3) adr = 5'd16;
      else if (r < 6)  adr = 5'd17;
      else if (r < 8)  adr = 5'd18;
      else if (r == 8) adr = 5'd19;
      else             adr = 5'($urandom_range(20, 31));
      cycle(1, 1'($urandom_range(0, 1)), adr, rand128(), 0, 0, '0, 0, 0, "rnd");
      side(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand128(),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), "rnd.side");
    end

    // Reset with the command engine busy and three TX entries queued.
    side(0, 0, '0, 1, 1, "pre_rst");
    for (int i = 0; i < DEPTH; i++) side(1, 0, '0, 0, 0, "pre_rst.drain");
    for (int i = 0; i < 3; i++) access(1, 5'd17, 128'(i + 40), "pre_rst.tx");
    cycle(1, 1, 5'd16, 128'h55, 0, 0, '0, 0, 0, "pre_rst.cmd");
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check_bit("mid_rst.ack", ack_o, 1'b0);
    check_bit("mid_rst.cmd_start", cmd_start_o, 1'b0);
    check_bit("mid_rst.tx_empty", tx_empty_o, 1'b1);
    check("mid_rst.tx_data", tx_data_o, '0);
    @(negedge wb_clock);
    @(negedge wb_clock);
    reset = 1'b1;
    side(0, 0, '0, 0, 0, "post_rst.idle");
    access(0, 5'd16, '0, "post_rst.st");
    check("post_rst.st.lit", a_data, 128'h14);
    check_bit("post_rst.cs.lit", a_cs, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
